simplez_loader: RTL
===================

// Module: simplez_loader
// PURPOSE
//  Serial program loader sitting upstream of the Simplez core. Takes bytes from the UART
//  receiver, rebuilds 12-bit instruction words and writes them into the program RAM that the
//  core fetches from. Holds the core in reset (cpu_rstn=0) during a load. Releases it only
//  after a frame with a valid checksum has been received.
// PARAMETERS
//  AW       9         program memory address width (words = 2**AW)
//  DW       12        program word width (fixed by the Simplez ISA)
//  SYNC     8'h55     frame start byte
//  TIMEOUT  1200000   max clk cycles between bytes inside a frame before abort
// PORTS
//  clk        in   1    system clock
//  rst        in   1    synchronous reset, active-high
//  rx_data    in   8    byte from UART receiver
//  rx_valid   in   1    1-cycle strobe, rx_data valid
//  mem_we     out  1    program RAM write enable (1-cycle pulse)
//  mem_addr   out  AW   program RAM write address
//  mem_din    out  DW   program RAM write data
//  cpu_rstn   out  1    active-low reset to Simplez core; 1 = core runs
//  done       out  1    last frame loaded and verified
//  error      out  1    last frame aborted (bad length, checksum or timeout)
// BEHAVIOUR
//  - Single clock domain. rst is synchronous and active-high.
//    On reset: state=IDLE, cpu_rstn=0, done=0, error=0, mem_we=0, mem_addr=0, mem_din=0,
//    word count=0, checksum=0, timeout counter=0.
//  - Frame format: SYNC, LEN_H, LEN_L, then LEN pairs {HI, LO}, then CSUM.
//    LEN = {LEN_H,LEN_L}; legal range is 1..2**AW.
//    Word = {HI[3:0], LO}. HI[7:4] are ignored.
//    CSUM = 8-bit mod-256 sum of LEN_H, LEN_L and all data bytes. SYNC is excluded.
//  - A byte is consumed only in a cycle where rx_valid=1.
//  - State machine:
//    IDLE:   SYNC -> LEN_H, clear checksum, word idx and error.
//            Any other byte is ignored.
//    LEN_H:  latch high byte -> LEN_L.
//    LEN_L:  if LEN=0 or LEN>2**AW -> ERR, else -> DATA_H.
//    DATA_H: latch HI -> DATA_L.
//    DATA_L: next cycle mem_we=1, mem_addr=word idx, mem_din={HI[3:0],LO}.
//            Then increment idx. If idx==LEN-1 -> CSUM, else -> DATA_H.
//    CSUM:   match -> RUN, mismatch -> ERR.
//    RUN:    done=1, cpu_rstn=1. A SYNC byte makes cpu_rstn=0 and done=0 on the next cycle,
//            then -> LEN_H (reload). Other bytes are ignored.
//    ERR:    error=1, cpu_rstn=0, done=0. A SYNC byte clears error and goes to LEN_H.
//  - Latency: all outputs are registered and change 1 cycle after the rx_valid that causes
//    them. mem_we is high for exactly 1 cycle per word.
//  - Writes happen before the checksum is verified. This is safe because the core is held in
//    reset until RUN.
//  - Timeout: in LEN_H..CSUM the counter increments each cycle without rx_valid and clears
//    on rx_valid. When it reaches TIMEOUT -> ERR. The counter is idle in IDLE, RUN and ERR.
//  - Checksum and idx widths: checksum wraps mod 256. idx is AW+1 bits so LEN=2**AW is
//    representable. mem_addr never wraps within a frame.
//  - rst mid-frame aborts immediately to the reset values. The next frame starts at addr 0.
// TESTING
//  1. rx 55 00 02 01 A5 0E 00 B6 -> writes [0]=0x1A5, [1]=0xE00, 2 mem_we pulses;
//     done=1, cpu_rstn=1, error=0.
//  2. Same frame with CSUM=B7 -> same 2 writes occur, then error=1, done=0, cpu_rstn=0.
//  3. rx 55 00 00 -> error=1 with no writes.
//     rx 55 02 01 (LEN=513, AW=9) -> error=1 with no writes.
//  4. rx 55 00 01 01, then no byte for TIMEOUT cycles -> error=1. A later good frame loads.
//  5. Bytes 12 34 AA before 55 00 01 0F FF 0F -> ignored; single write [0]=0xFFF, done=1.
//  6. rst pulsed between HI and LO of word 3 -> all outputs at reset values.
//     A new frame writes from addr 0.
//     After test 1, sending 55 in RUN -> cpu_rstn=0 next cycle, reload completes.

Source files
------------

// File: rtl/simplez_loader_if.sv
// Byte-in / word-out bus between the UART receiver, the loader and the program RAM.
interface simplez_loader_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 12
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  // Loader side: consumes UART bytes, drives the RAM write port
  modport master (
    input  rx_data,
    input  rx_valid,
    output mem_we,
    output mem_addr,
    output mem_din
  );

  // Environment side: UART receiver plus program RAM
  modport slave (
    output rx_data,
    output rx_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_din
  );
endinterface

// File: rtl/simplez_loader.sv
// Serial program loader: rebuilds 12-bit words from UART bytes, writes program RAM,
// holds the Simplez core in reset until a frame with a good checksum has arrived.
module simplez_loader #(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 12,
  parameter logic [7:0]  SYNC    = 8'h55,
  parameter int unsigned TIMEOUT = 1200000
) (
  input  logic            clk,
  input  logic            rst,
  simplez_loader_if.master bus,
  output logic            cpu_rstn,
  output logic            done,
  output logic            error
);

  localparam int unsigned MAXW = 1 << AW;
  localparam int unsigned IW   = AW + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t        state;
  logic [7:0]    len_h;
  logic [IW-1:0] len_last;
  logic [3:0]    hi;
  logic [IW-1:0] idx;
  logic [7:0]    csum;
  logic [TW-1:0] to_cnt;

  logic [15:0]   len_c;
  logic          len_bad_c;
  logic [7:0]    csum_next_c;
  logic          in_frame_c;
  logic          sync_c;

  // Frame length as seen on the LEN_L byte, plus its legality
  assign len_c       = {len_h, bus.rx_data};
  assign len_bad_c   = (len_c == 16'd0) || (32'(len_c) > MAXW);
  assign csum_next_c = csum + bus.rx_data;
  assign in_frame_c  = (state == S_LEN_H) || (state == S_LEN_L) || (state == S_DATA_H) ||
                       (state == S_DATA_L) || (state == S_CSUM);
  assign sync_c      = (bus.rx_data == SYNC);

  // Frame parser, RAM write port, inter-byte timeout and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cpu_rstn     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      len_h        <= '0;
      len_last     <= '0;
      hi           <= '0;
      idx          <= '0;
      csum         <= '0;
      to_cnt       <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (in_frame_c && !bus.rx_valid) begin
        // Stalled inside a frame: abort once the gap reaches TIMEOUT cycles
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          state    <= S_ERR;
          error    <= 1'b1;
          done     <= 1'b0;
          cpu_rstn <= 1'b0;
          to_cnt   <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else if (bus.rx_valid) begin
        to_cnt <= '0;
        case (state)
          S_IDLE, S_RUN, S_ERR: begin
            if (sync_c) begin
              state    <= S_LEN_H;
              csum     <= '0;
              idx      <= '0;
              error    <= 1'b0;
              done     <= 1'b0;
              cpu_rstn <= 1'b0;
            end
          end
          S_LEN_H: begin
            len_h <= bus.rx_data;
            csum  <= csum_next_c;
            state <= S_LEN_L;
          end
          S_LEN_L: begin
            csum <= csum_next_c;
            if (len_bad_c) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              len_last <= IW'(len_c - 16'd1);
              state    <= S_DATA_H;
            end
          end
          S_DATA_H: begin
            hi    <= bus.rx_data[3:0];
            csum  <= csum_next_c;
            state <= S_DATA_L;
          end
          S_DATA_L: begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= idx[AW-1:0];
            bus.mem_din  <= DW'({hi, bus.rx_data});
            csum         <= csum_next_c;
            idx          <= idx + IW'(1);
            state        <= (idx == len_last) ? S_CSUM : S_DATA_H;
          end
          S_CSUM: begin
            if (bus.rx_data == csum) begin
              state    <= S_RUN;
              done     <= 1'b1;
              cpu_rstn <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
